// File: rtl/lfsr_roll_display.sv
// Pseudo-random source for the lab display path: Fibonacci LFSR with free-run/step/roll advance modes.
// Latency: value updates on the edge that advances it; a roll finishes ROLL_CYCLES advances after the roll edge.
// Flow control: none; busy marks a roll in progress, valid pulses one cycle when the rolled value is final.
//
// Ports:
//   clk, rst           rising-edge clock, asynchronous active-high reset
//   en, step, load     free-run enable, single-advance pulse, load seed_in
//   seed_in            value to load (0 is replaced by 1)
//   roll               start a burst of ROLL_CYCLES advances
//   busy, valid        roll in progress / one-cycle roll-complete pulse
//   value              current LFSR state
//   seg                active-low {g,f,e,d,c,b,a} per hex digit, digit i at seg[7i+6:7i]
module lfsr_roll_display #(
   parameter int               WIDTH       = 8,
   parameter logic [WIDTH-1:0] TAPS        = 8'h1D,
   parameter logic [WIDTH-1:0] SEED        = WIDTH'(1),
   parameter int               ROLL_CYCLES = 16,
   localparam int              DIGITS      = (WIDTH + 3) / 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  step,
   input  logic                  load,
   input  logic [WIDTH-1:0]      seed_in,
   input  logic                  roll,
   output logic                  busy,
   output logic                  valid,
   output logic [WIDTH-1:0]      value,
   output logic [7*DIGITS-1:0]   seg
);

   // The all-zero state is a lockup point, so both seed sources are substituted with 1.
   localparam logic [WIDTH-1:0] RST_VAL  = (SEED == '0) ? WIDTH'(1) : SEED;
   localparam logic [7:0]       CNT_INIT = 8'(ROLL_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ROLL = 2'd1,
      DONE = 2'd2
   } fsm_t;

   fsm_t             fsm;
   logic [7:0]       cnt;
   logic [WIDTH-1:0] state;
   logic [WIDTH-1:0] nxt;
   logic [WIDTH-1:0] load_val;

   // Shift right, parity of the tapped bits enters at the MSB.
   assign nxt      = {^(state & TAPS), state[WIDTH-1:1]};
   assign load_val = (seed_in == '0) ? WIDTH'(1) : seed_in;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= RST_VAL;
         fsm   <= IDLE;
         cnt   <= '0;
      end else begin
         case (fsm)
            IDLE: begin
               if (load) begin
                  state <= load_val;
               end else if (roll) begin
                  // The roll edge itself is the first of the ROLL_CYCLES advances.
                  state <= nxt;
                  cnt   <= CNT_INIT;
                  fsm   <= (ROLL_CYCLES == 1) ? DONE : ROLL;
               end else if (step || en) begin
                  state <= nxt;
               end
            end
            ROLL: begin
               if (load) begin
                  // Abort: no completion pulse for an interrupted roll.
                  state <= load_val;
                  cnt   <= '0;
                  fsm   <= IDLE;
               end else begin
                  state <= nxt;
                  // Leave when the decrement reaches zero, so the final advance lands on the DONE edge.
                  if (cnt <= 8'd1) begin
                     cnt <= '0;
                     fsm <= DONE;
                  end else begin
                     cnt <= cnt - 8'd1;
                  end
               end
            end
            DONE: begin
               if (load) begin
                  state <= load_val;
               end
               fsm <= IDLE;
            end
            default: begin
               fsm <= IDLE;
            end
         endcase
      end
   end

   // Decoded straight from the state register, so neither output can glitch.
   assign busy  = (fsm == ROLL);
   assign valid = (fsm == DONE);
   assign value = state;

   function automatic logic [6:0] hex7(input logic [3:0] d);
      logic [6:0] p;
      p = 7'b1111111;
      case (d)
         4'h0: p = 7'b1000000;
         4'h1: p = 7'b1111001;
         4'h2: p = 7'b0100100;
         4'h3: p = 7'b0110000;
         4'h4: p = 7'b0011001;
         4'h5: p = 7'b0010010;
         4'h6: p = 7'b0000010;
         4'h7: p = 7'b1111000;
         4'h8: p = 7'b0000000;
         4'h9: p = 7'b0010000;
         4'hA: p = 7'b0001000;
         4'hB: p = 7'b0000011;
         4'hC: p = 7'b1000110;
         4'hD: p = 7'b0100001;
         4'hE: p = 7'b0000110;
         4'hF: p = 7'b0001110;
         default: p = 7'b1111111;
      endcase
      return p;
   endfunction

   // Top digit is zero-padded when WIDTH is not a multiple of 4.
   logic [4*DIGITS-1:0] val_pad;
   assign val_pad = (4*DIGITS)'(state);

   for (genvar i = 0; i < DIGITS; i++) begin : g_digit
      assign seg[7*i +: 7] = hex7(val_pad[4*i +: 4]);
   end

endmodule
